// File: rtl/rs_syndrome_bank_pkg.sv
// rs_pkg: shared GF(2^8) constants and helpers for the Reed-Solomon syndrome bank.
// Field arithmetic uses the primitive polynomial 0x11D with alpha = 0x02.
// Contents:
//   GF_PRIM / GF_ORDER   field polynomial and multiplicative group order
//   rs_state_e           framing FSM states
//   rs_beats             ceil(n / lanes), the number of beats per codeword
//   gf_exp_add           exponent addition modulo 255
//   gf256_mul            GF(2^8) multiply
//   gf256_power          alpha^e lookup
package rs_pkg;

  localparam logic [8:0] GF_PRIM  = 9'h11D;
  localparam int         GF_ORDER = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } rs_state_e;

  function automatic int rs_beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  // Both operands are in 0..254, so a single conditional subtract folds the sum back.
  function automatic logic [7:0] gf_exp_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 9'(GF_ORDER)) s = s - 9'(GF_ORDER);
    else                   s = s;
    return s[7:0];
  endfunction

  // Shift-and-add multiply with reduction by the low byte of the primitive polynomial.
  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      if (x[7]) x = {x[6:0], 1'b0} ^ GF_PRIM[7:0];
      else      x = {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // alpha^e built from the binary expansion of e: multiply in alpha^(2^i) for every set bit.
  function automatic logic [7:0] gf256_power(input logic [7:0] e);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = 8'h02;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf256_mul(r, sq);
      else      r = r;
      sq = gf256_mul(sq, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_syndrome_bank_beat_sum.sv
// rs_syn_beat_sum: one beat's contribution to one syndrome.
// o_sum = XOR over lanes l of (masked symbol l) * alpha^(i_base + l*ROOT mod 255).
// Ports:
//   i_data  LANES*8  beat symbols, lane 0 in bits [7:0]
//   i_mask  LANES    lane enable; masked lanes contribute zero
//   i_base  8        exponent of lane 0 for this beat (0..254)
//   o_sum   8        GF(2^8) sum of all lane terms
module rs_syn_beat_sum
  import rs_pkg::*;
#(
  parameter int LANES = 16,
  parameter int ROOT  = 1
) (
  input  logic [LANES*8-1:0] i_data,
  input  logic [LANES-1:0]   i_mask,
  input  logic [7:0]         i_base,
  output logic [7:0]         o_sum
);

  logic [7:0] w_term [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Lane offset l*ROOT is fixed per lane, so the runtime exponent path is a single mod-255 add.
    localparam logic [7:0] OFS = 8'((l * ROOT) % GF_ORDER);
    logic [7:0] w_sym;
    assign w_sym       = i_mask[l] ? i_data[8*l +: 8] : 8'h00;
    assign w_term[l]   = gf256_mul(w_sym, gf256_power(gf_exp_add(i_base, OFS)));
  end

  // XOR reduction of the lane terms; associativity lets synthesis balance the tree.
  always_comb begin
    o_sum = 8'h00;
    for (int l = 0; l < LANES; l++) begin
      o_sum = o_sum ^ w_term[l];
    end
  end

endmodule

// File: rtl/rs_syndrome_bank.sv
// rs_syndrome_bank: all NSYM Reed-Solomon syndromes of an RS(N,K) codeword over GF(2^8),
// LANES symbols per beat, framed by in_sop, result double-buffered toward the BM stage.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input beat handshake; in_sop marks the first beat
//   in_data             LANES symbols, lane 0 = earliest symbol
//   syn_valid/syn_ready output handshake; syn_data holds S_j at bits [8j+7:8j]
//   syn_zero            all syndromes zero, registered with syn_data
//   err_frame           one-cycle pulse on a framing violation
module rs_syndrome_bank
  import rs_pkg::*;
#(
  parameter int LANES = 16,
  parameter int NSYM  = 16,
  parameter int N     = 255,
  parameter int FCR   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic [LANES*8-1:0] in_data,
  output logic               syn_valid,
  input  logic               syn_ready,
  output logic [NSYM*8-1:0]  syn_data,
  output logic               syn_zero,
  output logic               err_frame
);

  localparam int            BEATS     = rs_beats(N, LANES);
  localparam int            CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam bit            ONE_BEAT  = (BEATS == 1);

  rs_state_e         r_state;
  rs_state_e         w_state_nxt;
  logic [CW-1:0]     r_beat_cnt;
  logic [CW-1:0]     w_beat_cnt_nxt;
  logic              r_syn_valid;
  logic              r_syn_zero;
  logic              r_err_frame;
  logic [NSYM*8-1:0] r_syn_data;
  logic [NSYM*8-1:0] w_final_vec;
  logic [LANES-1:0]  w_mask;
  logic              w_stall;
  logic              w_accept;
  logic              w_at_last;
  logic              w_start;
  logic              w_cont;
  logic              w_final;
  logic              w_err;

  // With a single-beat codeword every sop beat is final, so it must stall too.
  assign w_stall  = r_syn_valid && !syn_ready &&
                    ((r_state == ST_ACC && r_beat_cnt == LAST_BEAT) || ONE_BEAT);
  assign in_ready = !w_stall;
  assign w_accept = in_valid && in_ready;

  // A sop beat is always beat 0 of its codeword, whatever the counter says.
  assign w_at_last = in_sop ? ONE_BEAT : (r_beat_cnt == LAST_BEAT);

  for (genvar l = 0; l < LANES; l++) begin : g_mask
    localparam bit LIVE = (((BEATS - 1) * LANES + l) < N);
    assign w_mask[l] = !w_at_last || LIVE;
  end

  // Framing FSM next-state and beat classification.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_start        = 1'b0;
    w_cont         = 1'b0;
    w_final        = 1'b0;
    w_err          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && in_sop) begin
          w_start = 1'b1;
        end else if (w_accept) begin
          w_err = 1'b1;
        end else begin
          w_start = 1'b0;
        end
      end
      ST_ACC: begin
        if (w_accept && in_sop) begin
          w_err   = 1'b1;
          w_start = 1'b1;
        end else if (w_accept) begin
          w_cont = 1'b1;
          if (r_beat_cnt == LAST_BEAT) begin
            w_final        = 1'b1;
            w_state_nxt    = ST_IDLE;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          end
        end else begin
          w_cont = 1'b0;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
    // A sop beat starts a codeword; when it is also the only beat it completes at once.
    if (w_start && ONE_BEAT) begin
      w_final        = 1'b1;
      w_state_nxt    = ST_IDLE;
      w_beat_cnt_nxt = '0;
    end else if (w_start) begin
      w_state_nxt    = ST_ACC;
      w_beat_cnt_nxt = CW'(1);
    end else begin
      w_final = w_final;
    end
  end

  // Framing FSM state and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  for (genvar j = 0; j < NSYM; j++) begin : g_syn
    localparam int         ROOT = (j + FCR) % GF_ORDER;
    localparam logic [7:0] STEP = 8'((LANES * (j + FCR)) % GF_ORDER);

    logic [7:0] r_exp;
    logic [7:0] r_acc;
    logic [7:0] w_base;
    logic [7:0] w_sum;

    assign w_base = in_sop ? 8'h00 : r_exp;

    rs_syn_beat_sum #(
      .LANES (LANES),
      .ROOT  (ROOT)
    ) u_sum (
      .i_data (in_data),
      .i_mask (w_mask),
      .i_base (w_base),
      .o_sum  (w_sum)
    );

    assign w_final_vec[8*j +: 8] = (w_start ? 8'h00 : r_acc) ^ w_sum;

    // Per-syndrome base exponent and running accumulator.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_exp <= 8'h00;
        r_acc <= 8'h00;
      end else if (w_start) begin
        r_exp <= STEP;
        r_acc <= w_sum;
      end else if (w_cont) begin
        r_exp <= gf_exp_add(r_exp, STEP);
        r_acc <= r_acc ^ w_sum;
      end else begin
        r_exp <= r_exp;
        r_acc <= r_acc;
      end
    end
  end

  // Output buffer: a new final vector wins over a drain in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_syn_valid <= 1'b0;
      r_syn_data  <= '0;
      r_syn_zero  <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_err_frame <= w_err;
      if (w_final) begin
        r_syn_valid <= 1'b1;
        r_syn_data  <= w_final_vec;
        r_syn_zero  <= (w_final_vec == '0);
      end else if (syn_ready) begin
        r_syn_valid <= 1'b0;
      end else begin
        r_syn_valid <= r_syn_valid;
      end
    end
  end

  assign syn_valid = r_syn_valid;
  assign syn_data  = r_syn_data;
  assign syn_zero  = r_syn_zero;
  assign err_frame = r_err_frame;

endmodule

// File: tb/tb_rs_syndrome_bank.sv
// Directed bench for rs_syndrome_bank at default parameters (16 lanes, 16 syndromes, N=255).
module tb_rs_syndrome_bank;

  localparam logic [127:0] SYN_ALL01 = 128'h01010101010101010101010101010101;
  // S_j = alpha^(j+1) for a single 0x01 at k=1.
  localparam logic [127:0] SYN_R1    = 128'h4C261387CDE8743A1D80402010080402;
  // r_0 = r_1 = 0x01: each byte above XOR 0x01.
  localparam logic [127:0] SYN_R0R1  = 128'h4D271286CCE9753B1C81412111090503;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_sop;
  logic [127:0] in_data;
  logic         syn_valid;
  logic         syn_ready;
  logic [127:0] syn_data;
  logic         syn_zero;
  logic         err_frame;

  logic [7:0] cw [256];
  int checks;
  int failures;
  int err_cnt;
  int out_cnt;

  rs_syndrome_bank u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_data   (in_data),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn_data  (syn_data),
    .syn_zero  (syn_zero),
    .err_frame (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_frame) err_cnt++;
    if (syn_valid && syn_ready) out_cnt++;
  end

  task automatic clear_cw();
    for (int i = 0; i < 256; i++) cw[i] = 8'h00;
  endtask

  task automatic set_beat(input logic sop, input int b);
    in_valid = 1'b1;
    in_sop   = sop;
    for (int l = 0; l < 16; l++) in_data[8*l +: 8] = cw[b*16 + l];
  endtask

  task automatic drive_beat(input logic sop, input int b);
    int waited;
    set_beat(sop, b);
    waited = 0;
    while (!in_ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL beat_accept_timeout beat=%0d in_ready=%b required=1", b, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_beats(input int nb);
    for (int b = 0; b < nb; b++) drive_beat(b == 0, b);
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({syn_valid, syn_zero, err_frame} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000", {syn_valid, syn_zero, err_frame});
    end
    checks++;
    if (syn_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got=%h required=0", syn_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_all_zero();
    int e0;
    int o0;
    e0 = err_cnt;
    o0 = out_cnt;
    syn_ready = 1'b1;
    clear_cw();
    send_beats(16);
    checks++;
    if (syn_valid !== 1'b1 || out_cnt != o0) begin
      failures++;
      $display("FAIL zero_latency valid=%b early_outputs=%0d required valid=1 early=0", syn_valid, out_cnt - o0);
    end
    checks++;
    if (syn_data !== 128'h0 || syn_zero !== 1'b1) begin
      failures++;
      $display("FAIL zero_data got=%h zero=%b required=0 zero=1", syn_data, syn_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (syn_valid !== 1'b0 || err_cnt != e0) begin
      failures++;
      $display("FAIL zero_drain valid=%b errs=%0d required valid=0 errs=0", syn_valid, err_cnt - e0);
    end
  endtask

  task automatic test_impulse();
    syn_ready = 1'b1;
    clear_cw();
    cw[0] = 8'h01;
    send_beats(16);
    checks++;
    if (syn_valid !== 1'b1 || syn_data !== SYN_ALL01 || syn_zero !== 1'b0) begin
      failures++;
      $display("FAIL impulse_r0 got=%h valid=%b zero=%b required=%h valid=1 zero=0", syn_data, syn_valid, syn_zero, SYN_ALL01);
    end
    clear_cw();
    cw[1] = 8'h01;
    send_beats(16);
    checks++;
    if (syn_valid !== 1'b1 || syn_data !== SYN_R1) begin
      failures++;
      $display("FAIL impulse_r1 got=%h required=%h", syn_data, SYN_R1);
    end
    cw[0] = 8'h01;
    send_beats(16);
    checks++;
    if (syn_data !== SYN_R0R1) begin
      failures++;
      $display("FAIL impulse_r0r1 got=%h required=%h", syn_data, SYN_R0R1);
    end
  endtask

  task automatic test_position();
    syn_ready = 1'b1;
    clear_cw();
    cw[16] = 8'h01;
    send_beats(16);
    checks++;
    if (syn_data[15:0] !== 16'h9D4C) begin
      failures++;
      $display("FAIL pos_k16 got=%h required=9d4c", syn_data[15:0]);
    end
    clear_cw();
    cw[254] = 8'h01;
    send_beats(16);
    checks++;
    if (syn_data[15:0] !== 16'h478E) begin
      failures++;
      $display("FAIL pos_k254 got=%h required=478e", syn_data[15:0]);
    end
  endtask

  task automatic test_padding();
    syn_ready = 1'b1;
    clear_cw();
    cw[255] = 8'hFF;
    send_beats(16);
    checks++;
    if (syn_valid !== 1'b1 || syn_data !== 128'h0 || syn_zero !== 1'b1) begin
      failures++;
      $display("FAIL padding got=%h valid=%b zero=%b required=0 valid=1 zero=1", syn_data, syn_valid, syn_zero);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    int bad_ready;
    int bad_hold;
    @(posedge clk); #1;
    o0 = out_cnt;
    syn_ready = 1'b0;
    clear_cw();
    cw[0] = 8'h01;
    for (int b = 0; b < 16; b++) drive_beat(b == 0, b);
    checks++;
    if (syn_valid !== 1'b1 || syn_data !== SYN_ALL01) begin
      failures++;
      $display("FAIL b2b_first got=%h valid=%b required=%h valid=1", syn_data, syn_valid, SYN_ALL01);
    end
    clear_cw();
    cw[1] = 8'h01;
    bad_ready = 0;
    bad_hold  = 0;
    for (int b = 0; b < 15; b++) begin
      set_beat(b == 0, b);
      if (in_ready !== 1'b1) bad_ready++;
      @(posedge clk); #1;
      if (syn_data !== SYN_ALL01 || syn_valid !== 1'b1) bad_hold++;
    end
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL b2b_nonfinal_stall stalled_beats=%0d required=0", bad_ready);
    end
    set_beat(1'b0, 15);
    for (int c = 0; c < 3; c++) begin
      if (in_ready !== 1'b0) bad_ready++;
      @(posedge clk); #1;
      if (syn_data !== SYN_ALL01 || syn_valid !== 1'b1) bad_hold++;
    end
    checks++;
    if (bad_ready != 0 || bad_hold != 0) begin
      failures++;
      $display("FAIL b2b_final_stall ready_errs=%0d hold_errs=%0d required=0,0", bad_ready, bad_hold);
    end
    syn_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_release in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (syn_valid !== 1'b1 || syn_data !== SYN_R1) begin
      failures++;
      $display("FAIL b2b_second got=%h valid=%b required=%h valid=1", syn_data, syn_valid, SYN_R1);
    end
    @(posedge clk); #1;
    checks++;
    if (syn_valid !== 1'b0 || out_cnt - o0 != 2) begin
      failures++;
      $display("FAIL b2b_count valid=%b outputs=%0d required valid=0 outputs=2", syn_valid, out_cnt - o0);
    end
  endtask

  task automatic test_framing();
    int e0;
    int o0;
    syn_ready = 1'b1;
    e0 = err_cnt;
    o0 = out_cnt;
    clear_cw();
    cw[1] = 8'h01;
    for (int b = 0; b < 5; b++) drive_beat(b == 0, b);
    clear_cw();
    cw[1] = 8'h01;
    send_beats(16);
    checks++;
    if (syn_valid !== 1'b1 || syn_data !== SYN_R1) begin
      failures++;
      $display("FAIL frame_restart got=%h valid=%b required=%h valid=1", syn_data, syn_valid, SYN_R1);
    end
    @(posedge clk); #1;
    checks++;
    if (err_cnt - e0 != 1 || out_cnt - o0 != 1) begin
      failures++;
      $display("FAIL frame_abort errs=%0d outputs=%0d required errs=1 outputs=1", err_cnt - e0, out_cnt - o0);
    end
    o0 = out_cnt;
    drive_beat(1'b0, 3);
    in_valid = 1'b0;
    checks++;
    if (err_frame !== 1'b1) begin
      failures++;
      $display("FAIL frame_idle_pulse err_frame=%b required=1", err_frame);
    end
    @(posedge clk); #1;
    checks++;
    if (err_frame !== 1'b0 || syn_valid !== 1'b0 || out_cnt != o0) begin
      failures++;
      $display("FAIL frame_idle_drop err=%b valid=%b outputs=%0d required 0 0 0", err_frame, syn_valid, out_cnt - o0);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    syn_ready = 1'b0;
    clear_cw();
    cw[0] = 8'h01;
    send_beats(16);
    e0 = err_cnt;
    clear_cw();
    cw[1] = 8'h01;
    for (int b = 0; b < 8; b++) drive_beat(b == 0, b);
    set_beat(1'b0, 8);
    rst = 1'b1;
    #1;
    checks++;
    if ({syn_valid, syn_zero, err_frame} !== 3'b000 || syn_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_mid flags=%b data=%h required flags=000 data=0", {syn_valid, syn_zero, err_frame}, syn_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    syn_ready = 1'b1;
    @(posedge clk); #1;
    send_beats(16);
    checks++;
    if (syn_valid !== 1'b1 || syn_data !== SYN_R1 || err_cnt != e0) begin
      failures++;
      $display("FAIL reset_recover got=%h valid=%b errs=%0d required=%h valid=1 errs=0", syn_data, syn_valid, err_cnt - e0, SYN_R1);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    err_cnt   = 0;
    out_cnt   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_data   = '0;
    syn_ready = 1'b0;
    clear_cw();
    test_reset();
    test_all_zero();
    test_impulse();
    test_position();
    test_padding();
    test_back_to_back();
    test_framing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rs_syndrome_bank.md
Name: rs_syndrome_bank

Overview:
- Computes all 2t Reed-Solomon syndromes of one RS(N,K) codeword over GF(2^8), with primitive polynomial 0x11D, in a single pass.
- Accepts LANES symbols per beat and frames codewords itself from a start-of-codeword flag.
- Double-buffers the result so the next codeword can accumulate while the current result waits for the downstream Berlekamp-Massey stage.
- Successor to the single-syndrome slice: parametrised, backpressured, correctly framed.

Parameters:
- LANES, 16: symbols per input beat.
- NSYM, 16: number of syndromes (2t).
- N, 255: codeword length in symbols, 1..255.
- FCR, 1: first consecutive root. Syndrome j evaluates at alpha^(j+FCR).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_sop  in  1  first beat of a codeword
- in_data  in  LANES*8  symbols; lane 0 = bits [7:0] = earliest symbol
- syn_valid  out  1  syndrome vector valid
- syn_ready  in  1  downstream accepts the vector
- syn_data  out  NSYM*8  S_j at bits [8j+7:8j]
- syn_zero  out  1  all NSYM syndromes zero (no error); valid with syn_valid
- err_frame  out  1  one-cycle pulse on a framing violation

Behaviour:
- BEATS = ceil(N/LANES). Symbol index k = beat*LANES + lane. Lanes with k >= N on the final beat are masked to zero.
- Syndrome definition: S_j = XOR over k<N of r_k * alpha^(k*(j+FCR) mod 255).
- Per-syndrome exponent tracking: each syndrome keeps a base exponent register.
  - Cleared to 0 on the sop beat.
  - Stepped by (LANES*(j+FCR)) mod 255 per accepted beat, with mod-255 wrap.
  - No runtime multipliers in the exponent path.
- Beat counter beat_cnt, range 0..BEATS-1. States: IDLE and ACC.
  - IDLE + accepted beat with in_sop: start accumulation with accumulators = this beat's sums, beat_cnt = 1. Go to ACC, or, if BEATS==1, complete immediately.
  - IDLE + accepted beat without in_sop: beat discarded, err_frame pulses.
  - ACC + accepted beat without in_sop: accumulate, beat_cnt++.
  - ACC + accepted beat with in_sop: current codeword aborted, no output; err_frame pulses; restart as a new codeword.
  - Final beat (beat_cnt==BEATS-1) accepted: final accumulators transfer to the output register; return to IDLE.
- Latency: final beat accepted at edge T gives syn_valid=1 with the final values after edge T.
- Output register:
  - Holds its value while syn_valid && !syn_ready.
  - Clears syn_valid on handshake unless a new final beat loads it the same cycle. Simultaneous load and drain: the new value wins and syn_valid stays 1.
- in_ready = !(syn_valid && !syn_ready && state==ACC && beat_cnt==BEATS-1). Only the final beat ever stalls. Non-final beats always accept.
- syn_zero = NOR of the final vector, registered with syn_data.
- Reset, including mid-codeword: syn_valid=0, syn_data=0, syn_zero=0, err_frame=0, state IDLE, beat_cnt=0, accumulators 0, exponents 0. Partial codeword is lost without err_frame.
- in_data is ignored when in_valid=0. The exponent and counter do not advance on stalled cycles.

Decomposition:
- Package rs_pkg holds:
  - GF_PRIM = 9'h11D
  - GF_ORDER = 255
  - function for the ceil BEATS computation
  - function for mod-255 exponent addition
- Reuses the existing gf256_mul and gf256_power_lut.
- One natural sub-module, rs_syn_beat_sum: for one syndrome, LANES power lookups + multiplies + balanced XOR tree, with a lane mask input. Instantiated NSYM times.
- Top level holds the FSM, exponent registers, accumulators and output buffer.

Test Plan:
- All-zero codeword, 16 beats (defaults) -> syn_valid 1 cycle after beat 16, syn_data all 0x00, syn_zero=1, err_frame never.
- r_0=0x01, rest 0 -> every S_j=0x01, syn_zero=0. r_1=0x01 only -> S_0=0x02, S_1=0x04, S_7=0x1D (alpha^8), S_15=0x4C (alpha^16).
- Padding: final beat lane 15 (k=255) = 0xFF, all else 0 -> all syndromes 0x00, syn_zero=1.
- Backpressure: syn_ready=0, two back-to-back codewords -> first vector held stable, in_ready=0 only on the second codeword's final beat until syn_ready=1. The second vector appears the cycle after that beat is accepted. Vectors in order, no loss.
- Framing: in_sop on beat 5 of a codeword, then 16 beats of r_1=0x01 -> single err_frame pulse, one output equal to the r_1 case. A non-sop beat in IDLE -> err_frame pulse, no output.
- Reset asserted on beat 8 -> all outputs 0 immediately. A following clean codeword produces correct syndromes.
